// File: rtl/router_pkg.sv
// Shared constants and state type for the router input scheduler.
package router_pkg;
   localparam int DST_N  = 4;
   localparam int ADDR_W = 2;

   typedef enum logic {IDLE, BUSY} sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, searching upward mod N.
module rr_arbiter #(
   parameter int N = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant_oh,
   output logic [IW-1:0] grant_idx,
   output logic          grant_any
);
   logic [IW-1:0] pos;

   always_comb begin
      grant_idx = '0;
      grant_any = 1'b0;
      pos       = '0;
      for (int k = 0; k < N; k++) begin
         pos = IW'((int'(ptr) + k) % N);
         if (!grant_any && req[pos]) begin
            grant_any = 1'b1;
            grant_idx = pos;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_oh
         assign grant_oh[gi] = grant_any & (grant_idx == IW'(gi));
      end
   endgenerate
endmodule

// File: rtl/router_rr_scheduler.sv
// Packet-granular round-robin scheduler feeding the 1-to-4 router through a registered beat stage.
module router_rr_scheduler
   import router_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int N_REQ      = 4,
   parameter int MAX_BURST  = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_REQ-1:0]              req_valid,
   input  logic [N_REQ-1:0]              req_last,
   input  logic [ADDR_W*N_REQ-1:0]       req_addr,
   input  logic [DATA_WIDTH*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]              req_ready,
   input  logic [DST_N-1:0]              dst_ready,
   output logic [DATA_WIDTH-1:0]         rt_din,
   output logic                          rt_din_en,
   output logic [ADDR_W-1:0]             rt_addr,
   output logic [$clog2(N_REQ)-1:0]      grant_id,
   output logic                          busy,
   output logic                          burst_err
);
   localparam int GW = $clog2(N_REQ);
   localparam int CW = $clog2(MAX_BURST + 1);

   sched_state_t    state_reg, state_next;
   logic [GW-1:0]   grant_reg, grant_next;
   logic [GW-1:0]   rr_ptr_reg, rr_ptr_next;
   logic [ADDR_W-1:0] dst_reg, dst_next;
   logic [CW-1:0]   beat_cnt_reg, beat_cnt_next, beat_cnt_inc;
   logic            burst_err_reg, burst_err_next;
   logic [DATA_WIDTH-1:0] rt_din_reg;
   logic [ADDR_W-1:0] rt_addr_reg;
   logic            rt_din_en_reg;

   logic [N_REQ-1:0] arb_oh;
   logic [GW-1:0]    arb_idx;
   logic             arb_any;
   logic             accept;
   logic [ADDR_W-1:0] dst_sel;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr_reg),
      .grant_oh  (arb_oh),
      .grant_idx (arb_idx),
      .grant_any (arb_any)
   );

   assign beat_cnt_inc = beat_cnt_reg + CW'(1);

   always_comb begin
      state_next     = state_reg;
      grant_next     = grant_reg;
      rr_ptr_next    = rr_ptr_reg;
      dst_next       = dst_reg;
      beat_cnt_next  = beat_cnt_reg;
      burst_err_next = burst_err_reg;
      req_ready      = '0;
      accept         = 1'b0;
      dst_sel        = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_oh[i]) dst_sel = req_addr[ADDR_W*i +: ADDR_W];
      end
      case (state_reg)
         IDLE: begin
            if (arb_any) begin
               state_next = BUSY;
               grant_next = arb_idx;
               dst_next   = dst_sel;
            end
         end
         BUSY: begin
            req_ready[grant_reg] = req_valid[grant_reg] & dst_ready[dst_reg];
            accept               = req_ready[grant_reg];
            if (accept) begin
               beat_cnt_next = beat_cnt_inc;
               // A packet that hits the burst cap is closed as if its beat were last.
               if (req_last[grant_reg] || beat_cnt_inc == CW'(MAX_BURST)) begin
                  state_next    = IDLE;
                  beat_cnt_next = '0;
                  rr_ptr_next   = (grant_reg == GW'(N_REQ - 1)) ? '0 : grant_reg + GW'(1);
                  if (!req_last[grant_reg]) burst_err_next = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         grant_reg     <= '0;
         rr_ptr_reg    <= '0;
         dst_reg       <= '0;
         beat_cnt_reg  <= '0;
         burst_err_reg <= 1'b0;
         rt_din_reg    <= '0;
         rt_addr_reg   <= '0;
         rt_din_en_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         grant_reg     <= grant_next;
         rr_ptr_reg    <= rr_ptr_next;
         dst_reg       <= dst_next;
         beat_cnt_reg  <= beat_cnt_next;
         burst_err_reg <= burst_err_next;
         rt_din_en_reg <= accept;
         if (accept) begin
            rt_din_reg  <= req_data[grant_reg*DATA_WIDTH +: DATA_WIDTH];
            rt_addr_reg <= dst_reg;
         end
      end
   end

   assign rt_din    = rt_din_reg;
   assign rt_addr   = rt_addr_reg;
   assign rt_din_en = rt_din_en_reg;
   assign grant_id  = grant_reg;
   assign busy      = (state_reg == BUSY);
   assign burst_err = burst_err_reg;
endmodule
